// File: rtl/idex_skid_stage_pkg.sv
// Definitions shared by the skid-buffered pipeline stages: state encoding and
// the NOP control value.
package idex_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Replicated to the control width at the point of use; all-zero ctrl is a NOP.
  localparam logic NOP_CTRL = 1'b0;

  // Occupancy equals the state encoding; kept as a function so other stages agree.
  function automatic logic [1:0] occ_of(input skid_state_e st);
    return logic'(st == ST_FULL) ? 2'd2 : (st == ST_BUSY) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/idex_slot.sv
// One bundle register of the ID->EX skid stage: load enable plus synchronous clear.
// Holds datapath only; validity is tracked by the owning FSM.
module idex_slot #(
  parameter int BW = 64
) (
  input  logic          clk,
  input  logic          ld_i,
  input  logic          clr_i,
  input  logic [BW-1:0] d_i,
  output logic [BW-1:0] q_o
);

  logic [BW-1:0] slot_q;

  always_ff @(posedge clk) begin
    if (clr_i)     slot_q <= '0;
    else if (ld_i) slot_q <= d_i;
  end

  assign q_o = slot_q;

endmodule

// File: rtl/idex_skid_stage.sv
// ID->EX pipeline register with a 2-entry skid buffer, registered in_ready,
// synchronous flush and a saturating bubble counter.
module idex_skid_stage
  import idex_skid_stage_pkg::*;
#(
  parameter int W    = 16,
  parameter int NCH  = 3,
  parameter int CW   = 16,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [CW-1:0]     in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*W-1:0]  out_data,
  output logic [CW-1:0]     out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNTW-1:0]   bubble_cnt,
  input  logic              clr_stats
);

  localparam int DW = NCH * W;
  localparam int BW = DW + CW;

  skid_state_e    state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic [CNTW-1:0] bub_q, bub_d;

  logic           accept, consume;
  logic           main_ld, main_from_skid, skid_ld, slots_clr;
  logic [BW-1:0]  in_bundle, main_d, main_q, skid_q;

  assign in_bundle = {in_ctrl, in_data};
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  // Next state and slot control; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    slots_clr      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_ld = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && consume) begin
          main_ld = 1'b1;
        end else if (accept) begin
          skid_ld = 1'b1;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
      slots_clr = 1'b1;
    end
  end

  assign in_ready_d = (state_d != ST_FULL);
  assign main_d     = main_from_skid ? skid_q : in_bundle;

  always_comb begin
    bub_d = bub_q;
    if (clr_stats)
      bub_d = '0;
    else if (!out_valid && (bub_q != {CNTW{1'b1}}))
      bub_d = bub_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      bub_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      bub_q      <= bub_d;
    end
  end

  idex_slot #(.BW(BW)) u_main (
    .clk   (clk),
    .ld_i  (main_ld),
    .clr_i (slots_clr),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  idex_slot #(.BW(BW)) u_skid (
    .clk   (clk),
    .ld_i  (skid_ld),
    .clr_i (slots_clr),
    .d_i   (in_bundle),
    .q_o   (skid_q)
  );

  // A bubble always presents zero operands and a NOP control word.
  assign out_data   = out_valid ? main_q[DW-1:0] : '0;
  assign out_ctrl   = out_valid ? main_q[BW-1 -: CW] : {CW{NOP_CTRL}};
  assign in_ready   = in_ready_q;
  assign occupancy  = occ_of(state_q);
  assign bubble_cnt = bub_q;

endmodule
